wb_mem_responder: RTL

- Word-wide memory responder on the same single-master bus the control unit drives (addr/cs/we/wdata out, rdata/ack back).
- Serves instruction fetches, loads and stores from a local RAM with a programmable number of wait states.
- Provides a memory-mapped doorbell register that drives the core's Irq input.
- Sits between the control unit bus port and on-chip storage; it is the only responder on the bus.

---
 rtl/wb_mem_responder_if.sv | 30 +++
 rtl/wb_mem_responder.sv | 113 +++++++++++
 2 files changed

// File: rtl/wb_mem_responder_if.sv
// rtl/wb_mem_responder_if.sv - single-master word bus between control unit and memory responder
interface wb_mem_responder_if #(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
);
    logic [ADDR_SIZE-1:0] S_wb_addr;
    logic                 S_wb_cs;
    logic                 S_wb_we;
    logic [WORD_SIZE-1:0] S_wb_wdata;
    logic [WORD_SIZE-1:0] S_wb_rdata;
    logic                 S_wb_ack;

    modport master (
        output S_wb_addr,
        output S_wb_cs,
        output S_wb_we,
        output S_wb_wdata,
        input  S_wb_rdata,
        input  S_wb_ack
    );

    modport slave (
        input  S_wb_addr,
        input  S_wb_cs,
        input  S_wb_we,
        input  S_wb_wdata,
        output S_wb_rdata,
        output S_wb_ack
    );
endinterface

// File: rtl/wb_mem_responder.sv
// rtl/wb_mem_responder.sv - word RAM responder with wait states and doorbell interrupt register
module wb_mem_responder #(
    parameter int                   ADDR_SIZE   = 32,
    parameter int                   WORD_SIZE   = 32,
    parameter int                   DEPTH_LOG2  = 10,
    parameter int                   WAIT_STATES = 1,
    parameter logic [ADDR_SIZE-1:0] IRQ_ADDR    = 32'hFFFF_FFF0
) (
    input  logic                Clk,
    input  logic                Rst_n,
    wb_mem_responder_if.slave   bus,
    output logic                Irq,
    output logic                Busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic                  commit;
    logic                  in_range;
    logic                  is_irq;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [WORD_SIZE-1:0]  rd_val;

    logic [WORD_SIZE-1:0]  mem [0:(1<<DEPTH_LOG2)-1];

    assign word_idx = bus.S_wb_addr[DEPTH_LOG2+1:2];
    assign in_range = (bus.S_wb_addr[ADDR_SIZE-1:DEPTH_LOG2+2] == '0);
    assign is_irq   = (bus.S_wb_addr == IRQ_ADDR);

    // Next-state and wait-counter logic; a dropped cs in WAIT abandons the request.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.S_wb_cs) begin
                    if (WS == 4'd0) begin
                        state_nxt = ST_ACK;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WS;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.S_wb_cs) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd1) begin
                    state_nxt = ST_ACK;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // The edge that enters ACK is the single commit point of a transaction.
    assign commit = (state != ST_ACK) && (state_nxt == ST_ACK);

    // Read mux: RAM for in-range, doorbell level at IRQ_ADDR, zero elsewhere.
    always_comb begin
        rd_val = '0;
        if (in_range) begin
            rd_val = mem[word_idx];
        end else if (is_irq) begin
            rd_val = {{(WORD_SIZE-1){1'b0}}, Irq};
        end
    end

    // FSM state, registered bus outputs and doorbell; reset drops any transaction in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state          <= ST_IDLE;
            cnt            <= 4'd0;
            bus.S_wb_ack   <= 1'b0;
            bus.S_wb_rdata <= '0;
            Irq            <= 1'b0;
            Busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            bus.S_wb_ack   <= commit;
            Busy           <= (state_nxt != ST_IDLE);
            bus.S_wb_rdata <= (commit && !bus.S_wb_we) ? rd_val : '0;
            if (commit && !in_range && is_irq) begin
                Irq <= bus.S_wb_we ? bus.S_wb_wdata[0] : 1'b0;
            end
        end
    end

    // RAM write port; contents survive reset, and no write may land while reset is held.
    always_ff @(posedge Clk) begin
        if (Rst_n && commit && bus.S_wb_we && in_range) begin
            mem[word_idx] <= bus.S_wb_wdata;
        end
    end
endmodule
